me_ctu_scheduler: RTL and testbench
===================================

// Module: me_ctu_scheduler
// PURPOSE
//  Frame-level sequencer for the motion-estimation core: walks CTUs in raster order over one frame.
//  Per CTU: requests the current-block load, pulses begin_prepare to the PE-array controller,
//  waits for search completion, then hands the CTU result to the MV write-back stage.
//  Sits between the top-level frame control and the PE-array controller.
// PARAMETERS
//  FRAME_W_CTU  30      CTUs per row (>=1)
//  FRAME_H_CTU  17      CTU rows per frame (>=1)
//  COORD_W      8       width of ctu_x / ctu_y; must hold FRAME_W_CTU-1 and FRAME_H_CTU-1
//  TIMEOUT_CYC  4096    watchdog limit in SEARCH (used only with ME_WATCHDOG_EN)
// PORTS
//  clk            in   1        clock
//  rst            in   1        synchronous reset, active-high
//  frame_start    in   1        pulse: start a frame; ignored unless state==IDLE
//  cur_load_req   out  1        request current-CTU load; held until cur_load_ack
//  cur_load_ack   in   1        load complete; sampled only in LOAD
//  begin_prepare  out  1        one-cycle pulse to PE-array controller
//  search_done    in   1        pulse from PE-array controller; sampled only in SEARCH
//  res_valid      out  1        CTU result available for write-back
//  res_ready      in   1        write-back stage accepts result
//  res_timeout    out  1        qualifies res_valid: result produced by watchdog, MV invalid
//  ctu_x          out  COORD_W  current CTU column
//  ctu_y          out  COORD_W  current CTU row
//  frame_busy     out  1        high from LOAD of first CTU until DONE inclusive
//  frame_done     out  1        one-cycle pulse after the last CTU is written back
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE; all outputs 0; ctu_x=ctu_y=0; watchdog counter=0.
//  rst mid-frame aborts immediately; no frame_done; next frame restarts at CTU (0,0).
//  States: IDLE, LOAD, START, SEARCH, WB, ADV, DONE.
//  - IDLE:   frame_start=1 -> LOAD; ctu_x/ctu_y cleared to 0.
//  - LOAD:   cur_load_req=1; cur_load_ack=1 -> START (req drops the cycle after ack is seen).
//  - START:  begin_prepare=1 for exactly this cycle -> SEARCH.
//  - SEARCH: search_done=1 -> WB with res_timeout=0.
//  - WB:     res_valid=1, stays high and res_timeout stable until res_valid&res_ready -> ADV.
//  - ADV:    if ctu_x==FRAME_W_CTU-1: ctu_x=0; if ctu_y==FRAME_H_CTU-1 -> DONE else ctu_y+1 -> LOAD.
//            otherwise ctu_x+1 -> LOAD. ADV lasts one cycle.
//  - DONE:   frame_done=1 one cycle; ctu_x/ctu_y hold last-CTU values... then 0 on re-entry to LOAD.
//            -> IDLE.
//  Latency: frame_start to begin_prepare = 2 + ack wait cycles (ack same cycle as req -> 2).
//  Overhead per CTU beyond load/search/ready stalls: START+WB+ADV = 3 cycles.
//  Outputs registered; ctu_x/ctu_y valid and stable from LOAD through ADV of that CTU.
//  Spurious inputs: search_done outside SEARCH, cur_load_ack outside LOAD,
//  frame_start outside IDLE -> ignored, no state change.
//  Simultaneous frame_start and rst -> reset wins.
//  FRAME_W_CTU=1 and/or FRAME_H_CTU=1 legal: single-column/row/CTU frames wrap correctly.
// CONFIGURATION
//  ME_WATCHDOG_EN defined: counter clears on SEARCH entry, increments each SEARCH cycle.
//    Reaching TIMEOUT_CYC without search_done -> WB with res_timeout=1; frame continues with the next CTU.
//    search_done and timeout in the same cycle -> search_done wins (res_timeout=0).
//  ME_WATCHDOG_EN undefined: no counter; SEARCH waits indefinitely; res_timeout tied 0.
// TESTING
//  1. W=2,H=2, ack same cycle as req, search_done 10 cycles after begin_prepare, ready=1
//     -> coordinates (0,0),(1,0),(0,1),(1,1); 4 begin_prepare pulses; frame_done once.
//  2. res_ready low 5 cycles in WB -> res_valid held 6 cycles; ctu_x/y stable; then advances.
//  3. search_done pulsed during LOAD and frame_start pulsed during SEARCH -> no effect;
//     frame_done count unchanged.
//  4. rst asserted in SEARCH of CTU (1,0) -> all outputs 0 next cycle; a new frame_start
//     restarts at (0,0).
//  5. W=1,H=1 -> exactly one begin_prepare, one res_valid handshake, frame_done 1 cycle after ADV.
//  6. ME_WATCHDOG_EN, TIMEOUT_CYC=16, no search_done -> res_valid with res_timeout=1 after
//     16 SEARCH cycles; next CTU loads; search_done arriving on cycle 16 -> res_timeout=0.

Source files
------------

// File: rtl/me_ctu_if.sv
// Handshake bundle between the CTU scheduler (master) and the frame control,
// load, PE-array and write-back side (slave).
interface me_ctu_if #(
    parameter int unsigned COORD_W = 8
);
    logic               frame_start;
    logic               cur_load_req;
    logic               cur_load_ack;
    logic               begin_prepare;
    logic               search_done;
    logic               res_valid;
    logic               res_ready;
    logic               res_timeout;
    logic [COORD_W-1:0] ctu_x;
    logic [COORD_W-1:0] ctu_y;
    logic               frame_busy;
    logic               frame_done;

    modport master (
        input  frame_start, cur_load_ack, search_done, res_ready,
        output cur_load_req, begin_prepare, res_valid, res_timeout,
        output ctu_x, ctu_y, frame_busy, frame_done
    );

    modport slave (
        output frame_start, cur_load_ack, search_done, res_ready,
        input  cur_load_req, begin_prepare, res_valid, res_timeout,
        input  ctu_x, ctu_y, frame_busy, frame_done
    );
endinterface

// File: rtl/me_ctu_scheduler.sv
// Raster-order CTU sequencer: load, prepare, search, write-back per CTU over one frame.
// Define ME_WATCHDOG_EN to bound SEARCH by TIMEOUT_CYC cycles (result flagged res_timeout).
module me_ctu_scheduler #(
    parameter int unsigned FRAME_W_CTU = 30,
    parameter int unsigned FRAME_H_CTU = 17,
    parameter int unsigned COORD_W     = 8,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input logic      clk,
    input logic      rst,
    me_ctu_if.master bus
);
    typedef enum logic [2:0] {
        StIdle, StLoad, StStart, StSearch, StWb, StAdv, StDone
    } state_e;

    localparam logic [COORD_W-1:0] LastX = COORD_W'(FRAME_W_CTU - 1);
    localparam logic [COORD_W-1:0] LastY = COORD_W'(FRAME_H_CTU - 1);

    if (FRAME_W_CTU < 1 || FRAME_H_CTU < 1 || TIMEOUT_CYC < 1 ||
        $clog2(FRAME_W_CTU) > COORD_W || $clog2(FRAME_H_CTU) > COORD_W) begin : g_bad_param
        $error("me_ctu_scheduler: illegal parameter set");
    end

    state_e             state_q, state_d;
    logic [COORD_W-1:0] ctu_x_q, ctu_x_d;
    logic [COORD_W-1:0] ctu_y_q, ctu_y_d;
    logic               cur_load_req_q, cur_load_req_d;
    logic               begin_prepare_q, begin_prepare_d;
    logic               res_valid_q, res_valid_d;
    logic               res_timeout_q, res_timeout_d;
    logic               frame_busy_q, frame_busy_d;
    logic               frame_done_q, frame_done_d;
    logic               timeout_hit;

`ifdef ME_WATCHDOG_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYC + 1);
    logic [WdW-1:0] wd_cnt_q, wd_cnt_d;

    // Counter holds (SEARCH cycles elapsed - 1), so the hit lands on cycle TIMEOUT_CYC.
    assign timeout_hit = (wd_cnt_q == WdW'(TIMEOUT_CYC - 1));
    assign wd_cnt_d    = (state_q == StSearch && state_d == StSearch) ? wd_cnt_q + WdW'(1) : '0;

    always_ff @(posedge clk) begin
        if (rst) wd_cnt_q <= '0;
        else     wd_cnt_q <= wd_cnt_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ctu_x_d = ctu_x_q;
        ctu_y_d = ctu_y_q;
        unique case (state_q)
            StIdle: begin
                if (bus.frame_start) begin
                    state_d = StLoad;
                    ctu_x_d = '0;
                    ctu_y_d = '0;
                end
            end
            StLoad:   if (bus.cur_load_ack) state_d = StStart;
            StStart:  state_d = StSearch;
            StSearch: if (bus.search_done || timeout_hit) state_d = StWb;
            StWb:     if (res_valid_q && bus.res_ready) state_d = StAdv;
            StAdv: begin
                if (ctu_x_q != LastX) begin
                    ctu_x_d = ctu_x_q + COORD_W'(1);
                    state_d = StLoad;
                end else if (ctu_y_q != LastY) begin
                    ctu_x_d = '0;
                    ctu_y_d = ctu_y_q + COORD_W'(1);
                    state_d = StLoad;
                end else begin
                    // Last CTU: coordinates stay on it through DONE.
                    state_d = StDone;
                end
            end
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        cur_load_req_d  = (state_d == StLoad);
        begin_prepare_d = (state_d == StStart);
        res_valid_d     = (state_d == StWb);
        frame_busy_d    = (state_d != StIdle);
        frame_done_d    = (state_d == StDone);
        // Timeout flag latched on SEARCH exit; search_done has priority over the watchdog.
        res_timeout_d   = (state_d == StWb) &&
                          ((state_q == StWb) ? res_timeout_q : !bus.search_done && timeout_hit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            ctu_x_q         <= '0;
            ctu_y_q         <= '0;
            cur_load_req_q  <= 1'b0;
            begin_prepare_q <= 1'b0;
            res_valid_q     <= 1'b0;
            res_timeout_q   <= 1'b0;
            frame_busy_q    <= 1'b0;
            frame_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            ctu_x_q         <= ctu_x_d;
            ctu_y_q         <= ctu_y_d;
            cur_load_req_q  <= cur_load_req_d;
            begin_prepare_q <= begin_prepare_d;
            res_valid_q     <= res_valid_d;
            res_timeout_q   <= res_timeout_d;
            frame_busy_q    <= frame_busy_d;
            frame_done_q    <= frame_done_d;
        end
    end

    assign bus.cur_load_req  = cur_load_req_q;
    assign bus.begin_prepare = begin_prepare_q;
    assign bus.res_valid     = res_valid_q;
    assign bus.res_timeout   = res_timeout_q;
    assign bus.ctu_x         = ctu_x_q;
    assign bus.ctu_y         = ctu_y_q;
    assign bus.frame_busy    = frame_busy_q;
    assign bus.frame_done    = frame_done_q;
endmodule

// File: tb/tb_me_ctu_scheduler.sv
// Randomized bench for me_ctu_scheduler: 2x2, 1x1 and 3x2 frames checked against
// a transaction-level model (raster order, handshake latencies, pulse counts).
module tb_me_ctu_scheduler;
    localparam int unsigned CW    = 8;
    localparam int          TMO   = 16;
    localparam int          RAND  = -2;
    localparam int          NEVER = -1;
    localparam int          NONE  = -1;

    logic clk = 1'b0;
    logic rst;
    logic frame_start, cur_load_ack, search_done, res_ready;
    int   sel;
    int   n_vec = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    int   bp_cnt = 0;

    always #5 clk = ~clk;

    me_ctu_if #(.COORD_W(CW)) bus_a ();
    me_ctu_if #(.COORD_W(CW)) bus_b ();
    me_ctu_if #(.COORD_W(CW)) bus_c ();

    assign {bus_a.frame_start, bus_a.cur_load_ack, bus_a.search_done, bus_a.res_ready} =
        (sel == 0) ? {frame_start, cur_load_ack, search_done, res_ready} : 4'b0;
    assign {bus_b.frame_start, bus_b.cur_load_ack, bus_b.search_done, bus_b.res_ready} =
        (sel == 1) ? {frame_start, cur_load_ack, search_done, res_ready} : 4'b0;
    assign {bus_c.frame_start, bus_c.cur_load_ack, bus_c.search_done, bus_c.res_ready} =
        (sel == 2) ? {frame_start, cur_load_ack, search_done, res_ready} : 4'b0;

    me_ctu_scheduler #(.FRAME_W_CTU(2), .FRAME_H_CTU(2), .COORD_W(CW), .TIMEOUT_CYC(TMO))
        u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    me_ctu_scheduler #(.FRAME_W_CTU(1), .FRAME_H_CTU(1), .COORD_W(CW), .TIMEOUT_CYC(TMO))
        u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    me_ctu_scheduler #(.FRAME_W_CTU(3), .FRAME_H_CTU(2), .COORD_W(CW), .TIMEOUT_CYC(TMO))
        u_dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    logic [21:0] obs_a, obs_b, obs_c, obs;
    assign obs_a = {bus_a.cur_load_req, bus_a.begin_prepare, bus_a.res_valid, bus_a.res_timeout,
                    bus_a.frame_busy, bus_a.frame_done, bus_a.ctu_x, bus_a.ctu_y};
    assign obs_b = {bus_b.cur_load_req, bus_b.begin_prepare, bus_b.res_valid, bus_b.res_timeout,
                    bus_b.frame_busy, bus_b.frame_done, bus_b.ctu_x, bus_b.ctu_y};
    assign obs_c = {bus_c.cur_load_req, bus_c.begin_prepare, bus_c.res_valid, bus_c.res_timeout,
                    bus_c.frame_busy, bus_c.frame_done, bus_c.ctu_x, bus_c.ctu_y};
    assign obs = (sel == 0) ? obs_a : (sel == 1) ? obs_b : obs_c;

    wire          o_req  = obs[21];
    wire          o_bp   = obs[20];
    wire          o_rv   = obs[19];
    wire          o_rt   = obs[18];
    wire          o_busy = obs[17];
    wire          o_done = obs[16];
    wire [CW-1:0] o_x    = obs[15:8];
    wire [CW-1:0] o_y    = obs[7:0];

    always @(negedge clk) begin
        if (o_done === 1'b1) done_cnt++;
        if (o_bp === 1'b1) bp_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected SEARCH length given that search_done is raised on SEARCH cycle d+1.
    function automatic int exp_search_len(input int d);
`ifdef ME_WATCHDOG_EN
        if (d < 0 || d + 1 > TMO) return TMO;
`endif
        return d + 1;
    endfunction

    function automatic bit exp_timeout(input int d);
`ifdef ME_WATCHDOG_EN
        return (d < 0 || d + 1 > TMO);
`else
        return (d < 0);
`endif
    endfunction

    task automatic run_frame(input int w, input int h, input int fa, input int fd,
                             input int fs, input int abort_idx);
        int a, d, s, k, hold, done0, bp0;
        bit rv_seen;
        done0 = done_cnt;
        bp0   = bp_cnt;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int i = 0; i < w * h; i++) begin
            a = (fa == RAND) ? int'($urandom_range(0, 3)) : fa;
            d = (fd == RAND) ? int'($urandom_range(0, 11)) : fd;
            s = (fs == RAND) ? int'($urandom_range(0, 3)) : fs;
            check_eq("load_req", o_req, 1);
            check_eq("load_x", o_x, i % w);
            check_eq("load_y", o_y, i / w);
            check_eq("load_busy", o_busy, 1);
            for (int j = 0; j < a; j++) begin
                search_done = 1'($urandom_range(0, 1));
                step();
                search_done = 1'b0;
                check_eq("req_held", o_req, 1);
            end
            cur_load_ack = 1'b1;
            step();
            cur_load_ack = 1'b0;
            check_eq("bp_pulse", o_bp, 1);
            check_eq("req_drop", o_req, 0);
            step();
            check_eq("bp_single", o_bp, 0);
            if (i == abort_idx) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                check_eq("abort_outs", 32'(obs), 0);
                return;
            end
            k = 0;
            rv_seen = 1'b0;
            while (!rv_seen && k < 64) begin
                k++;
                search_done = (d >= 0 && k == d + 1);
                if (!search_done) begin
                    frame_start  = 1'($urandom_range(0, 1));
                    cur_load_ack = 1'($urandom_range(0, 1));
                end
                step();
                {search_done, frame_start, cur_load_ack} = 3'b0;
                rv_seen = o_rv;
            end
            check_eq("search_len", k, exp_search_len(d));
            check_eq("res_timeout", o_rt, exp_timeout(d));
            check_eq("wb_x", o_x, i % w);
            check_eq("wb_y", o_y, i / w);
            hold = 1;
            for (int j = 0; j < s; j++) begin
                search_done = 1'($urandom_range(0, 1));
                step();
                search_done = 1'b0;
                hold += int'(o_rv);
                check_eq("stall_x", o_x, i % w);
                check_eq("stall_rt", o_rt, exp_timeout(d));
            end
            res_ready = 1'b1;
            step();
            res_ready = 1'b0;
            check_eq("rv_hold", hold, s + 1);
            check_eq("adv_rv", o_rv, 0);
            check_eq("adv_req", o_req, 0);
            check_eq("adv_busy", o_busy, 1);
            step();
        end
        check_eq("frame_done", o_done, 1);
        check_eq("done_busy", o_busy, 1);
        step();
        check_eq("done_pulse", o_done, 0);
        check_eq("idle_busy", o_busy, 0);
        check_eq("done_count", done_cnt - done0, 1);
        check_eq("bp_count", bp_cnt - bp0, w * h);
    endtask

    initial begin
        {frame_start, cur_load_ack, search_done, res_ready} = 4'b0;
        sel = 0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            sel = i;
            #1;
            check_eq("reset_outs", 32'(obs), 0);
        end
        sel = 0;
        #1;

        run_frame(2, 2, 0, 9, 0, NONE);
        run_frame(2, 2, RAND, RAND, 5, NONE);
        begin
            int d0;
            d0 = done_cnt;
            run_frame(2, 2, RAND, RAND, RAND, 1);
            repeat (3) begin
                step();
                check_eq("post_abort_busy", o_busy, 0);
            end
            check_eq("abort_no_done", done_cnt - d0, 0);
        end
        run_frame(2, 2, RAND, RAND, RAND, NONE);

        frame_start = 1'b1;
        rst = 1'b1;
        step();
        {frame_start, rst} = 2'b0;
        step();
        check_eq("rst_wins_req", o_req, 0);
        check_eq("rst_wins_busy", o_busy, 0);

        sel = 1;
        #1;
        repeat (3) run_frame(1, 1, RAND, RAND, RAND, NONE);

        sel = 2;
        #1;
        repeat (4) run_frame(3, 2, RAND, RAND, RAND, NONE);

        sel = 0;
        #1;
`ifdef ME_WATCHDOG_EN
        run_frame(2, 2, RAND, NEVER, RAND, NONE);
        run_frame(2, 2, RAND, TMO - 1, RAND, NONE);
        run_frame(2, 2, RAND, TMO, RAND, NONE);
`else
        run_frame(2, 2, RAND, 30, RAND, NONE);
`endif

        {search_done, cur_load_ack, res_ready} = 3'b111;
        repeat (3) begin
            step();
            check_eq("idle_spurious_req", o_req, 0);
            check_eq("idle_spurious_busy", o_busy, 0);
        end
        {search_done, cur_load_ack, res_ready} = 3'b000;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL sim_timeout: got no finish, expected finish before 500000ns");
        $fatal(1);
    end
endmodule
